// File: rtl/ccc_lock_reset_seq.sv
// Staged reset sequencer for a CCC PLL: filters the synchronized lock, then
// releases NUM_STAGES active-low resets in order, with lock-timeout fault handling.
module ccc_lock_reset_seq #(
    parameter int unsigned LOCK_FILTER = 16,
    parameter int unsigned STAGE_DELAY = 64,
    parameter int unsigned NUM_STAGES  = 3,
    parameter int unsigned TIMEOUT     = 65535
) (
    input  logic                  PCLK,
    input  logic                  PRESERN,
    input  logic                  LOCK_IN,
    input  logic                  BYPASS_LOCK,
    input  logic                  SW_RST_REQ,
    output logic [NUM_STAGES-1:0] RST_N_OUT,
    output logic                  READY,
    output logic                  LOCK_FAULT,
    output logic [2:0]            STATE,
    output logic [7:0]            LOSS_CNT
);

    typedef enum logic [2:0] {
        S_WAIT_LOCK = 3'd0,
        S_FILTER    = 3'd1,
        S_RELEASE   = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_e;

    localparam logic [15:0] FILTER_LAST  = 16'(LOCK_FILTER - 1);
    localparam logic [15:0] DELAY_LAST   = 16'(STAGE_DELAY - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [2:0]  STAGE_LAST   = 3'(NUM_STAGES - 1);

    logic                  sync1_q, sync2_q;
    logic                  eff_lock;

    state_e                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [2:0]            stage_q, stage_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic                  ready_q, ready_d;
    logic                  fault_q, fault_d;
    logic [7:0]            loss_q, loss_d;
    logic                  restart;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= LOCK_IN;
            sync2_q <= sync1_q;
        end
    end

    assign eff_lock = sync2_q | BYPASS_LOCK;

    // NOTE: every variable gets a default at the top of the block, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stage_d = stage_q;
        rst_n_d = rst_n_q;
        ready_d = ready_q;
        fault_d = fault_q;
        loss_d  = loss_q;
        restart = 1'b0;

        case (state_q)
            S_WAIT_LOCK: begin
                if (SW_RST_REQ) begin
                    cnt_d = '0;
                end else if (eff_lock) begin
                    state_d = S_FILTER;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_FAULT;
                    fault_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_FILTER: begin
                if (!eff_lock || SW_RST_REQ) begin
                    restart = 1'b1;
                end else if (cnt_q == FILTER_LAST) begin
                    state_d = S_RELEASE;
                    cnt_d   = '0;
                    stage_d = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_RELEASE: begin
                if (!eff_lock || SW_RST_REQ) begin
                    restart = 1'b1;
                end else if (cnt_q == DELAY_LAST) begin
                    cnt_d   = '0;
                    stage_d = stage_q + 3'd1;
                    for (int i = 0; i < NUM_STAGES; i++) begin
                        if (stage_q == 3'(i)) rst_n_d[i] = 1'b1;
                    end
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_RUN;
                        ready_d = 1'b1;
                        stage_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            S_RUN: begin
                // A lock loss coinciding with a software request counts as a loss.
                if (!eff_lock) begin
                    restart = 1'b1;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end else if (SW_RST_REQ) begin
                    restart = 1'b1;
                end
            end

            S_FAULT: begin
                rst_n_d = '0;
                ready_d = 1'b0;
                if (SW_RST_REQ) begin
                    state_d = S_WAIT_LOCK;
                    fault_d = 1'b0;
                    cnt_d   = '0;
                end
            end

            default: restart = 1'b1;
        endcase

        if (restart) begin
            state_d = S_WAIT_LOCK;
            cnt_d   = '0;
            stage_d = '0;
            rst_n_d = '0;
            ready_d = 1'b0;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state_q <= S_WAIT_LOCK;
            cnt_q   <= '0;
            stage_q <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            fault_q <= 1'b0;
            loss_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            fault_q <= fault_d;
            loss_q  <= loss_d;
        end
    end

    assign RST_N_OUT  = rst_n_q;
    assign READY      = ready_q;
    assign LOCK_FAULT = fault_q;
    assign STATE      = state_q;
    assign LOSS_CNT   = loss_q;

endmodule

// File: doc/ccc_lock_reset_seq.md
CCC_LOCK_RESET_SEQ -- requirements
Module: ccc_lock_reset_seq

Interface
REQ-001 The block SHALL have parameter LOCK_FILTER, default 16: consecutive locked cycles required before reset release.
REQ-002 The block SHALL have parameter STAGE_DELAY, default 64: cycles between successive stage releases.
REQ-003 The block SHALL have parameter NUM_STAGES, default 3: number of sequenced reset outputs (1..8).
REQ-004 The block SHALL have parameter TIMEOUT, default 65535: maximum WAIT_LOCK cycles before fault.
REQ-005 The block SHALL have port PCLK, input, 1 bit: the single clock, all flops rising-edge.
REQ-006 The block SHALL have port PRESERN, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port LOCK_IN, input, 1 bit: CCC PLL lock, asynchronous to PCLK.
REQ-008 The block SHALL have port BYPASS_LOCK, input, 1 bit: quasi-static; 1 forces lock true when the CCC PLL is bypassed.
REQ-009 The block SHALL have port SW_RST_REQ, input, 1 bit: synchronous one-cycle request to re-sequence.
REQ-010 The block SHALL have port RST_N_OUT, output, NUM_STAGES bits: active-low stage resets; bit 0 is released first.
REQ-011 The block SHALL have port READY, output, 1 bit: all stages released.
REQ-012 The block SHALL have port LOCK_FAULT, output, 1 bit: sticky lock-timeout flag.
REQ-013 The block SHALL have port STATE, output, 3 bits: current FSM state encoding.
REQ-014 The block SHALL have port LOSS_CNT, output, 8 bits: saturating count of lock losses while in RUN.

Function
REQ-015 LOCK_IN SHALL pass through a 2-flop synchronizer; eff_lock = sync_lock OR BYPASS_LOCK.
REQ-016 The FSM SHALL have states WAIT_LOCK=0, FILTER=1, RELEASE=2, RUN=3, FAULT=4; codes 5-7 SHALL go to WAIT_LOCK.
REQ-017 WAIT_LOCK: one 16-bit counter SHALL increment each cycle.
  - eff_lock=1: go to FILTER with counter cleared.
  - Otherwise, counter==TIMEOUT-1: go to FAULT and set LOCK_FAULT.
REQ-018 FILTER: the counter SHALL increment on each eff_lock=1 cycle.
  - eff_lock=0: return to WAIT_LOCK with counter cleared.
  - eff_lock=1 and counter==LOCK_FILTER-1: go to RELEASE with counter cleared, stage index k=0.
REQ-019 RELEASE: the counter SHALL increment each cycle.
  - counter==STAGE_DELAY-1: next edge sets RST_N_OUT[k]=1, clears the counter, increments k.
  - When k==NUM_STAGES-1 is released, that same edge SHALL enter RUN and set READY=1.
REQ-020 Released stages SHALL stay released; unreleased stages SHALL stay 0.
REQ-021 eff_lock=0 in RELEASE or RUN SHALL, on the next edge:
  - clear all RST_N_OUT and READY;
  - clear counter and k;
  - enter WAIT_LOCK.
  Only a loss in RUN SHALL increment LOSS_CNT, which saturates at 255.
REQ-022 SW_RST_REQ=1 in FILTER, RELEASE or RUN SHALL have the same effect as REQ-021, without incrementing LOSS_CNT.
REQ-023 SW_RST_REQ=1 in WAIT_LOCK SHALL only clear the counter.
REQ-024 FAULT: all RST_N_OUT SHALL be 0 and READY SHALL be 0.
  - Only SW_RST_REQ=1 exits FAULT, to WAIT_LOCK, and clears LOCK_FAULT.
  - LOCK_IN changes SHALL be ignored in FAULT.
REQ-025 Simultaneous lock loss and SW_RST_REQ in RUN SHALL count as a lock loss (LOSS_CNT increments once).
REQ-026 All outputs SHALL be registered; STATE SHALL reflect the registered state.

Reset
REQ-027 PRESERN=0 SHALL asynchronously set:
  - RST_N_OUT=0, READY=0, LOCK_FAULT=0, LOSS_CNT=0;
  - STATE=WAIT_LOCK, counter=0, k=0, synchronizer flops=0.
REQ-028 Reset assertion mid-RELEASE or mid-RUN SHALL immediately re-assert every RST_N_OUT bit.
REQ-029 After PRESERN deasserts, sequencing SHALL restart from WAIT_LOCK.

Verification (LOCK_FILTER=16, STAGE_DELAY=64, NUM_STAGES=3, TIMEOUT=1000)
REQ-030 LOCK_IN rises before edge e0 and stays high -> RST_N_OUT[0]=1 at e82, [1] at e146, [2] at e210; READY=1 and STATE=3 at e210.
REQ-031 LOCK_IN held 0 -> LOCK_FAULT=1 and STATE=4 after 1000 WAIT_LOCK cycles; outputs stay 0. A later SW_RST_REQ pulse -> STATE=0, LOCK_FAULT=0.
REQ-032 LOCK_IN glitches low for 1 cycle during FILTER -> return to WAIT_LOCK; the full 16-cycle filter restarts; no stage is released early.
REQ-033 In RUN, LOCK_IN drops -> 2 sync edges later RST_N_OUT=3'b000, READY=0, LOSS_CNT=1; 300 losses -> LOSS_CNT=255.
REQ-034 BYPASS_LOCK=1 with LOCK_IN=0 -> full sequence completes, RUN reached, timings as REQ-030 minus the 2 synchronizer edges.
REQ-035 PRESERN asserted after RST_N_OUT[0]=1 -> all outputs 0 asynchronously; after deassertion the sequence restarts from WAIT_LOCK.
